johnson_seq_monitor: RTL and testbench
======================================

// Module: johnson_seq_monitor
// PURPOSE
//  Downstream consumer of the 4-bit Johnson counter output. It samples q each enabled
//  cycle, decodes it to a 3-bit phase and an 8-bit one-hot phase, and checks every code
//  and every step against the legal 8-state sequence. It tracks lock status, counts
//  full revolutions and counts errors, feeding phase sequencing and health status.
// PARAMETERS
//  LOCK_CNT   4   consecutive correct steps needed to assert locked (1..15)
//  ERR_CNT_W  8   width of saturating error counter
//  REV_CNT_W  16  width of revolution counter (wraps modulo 2^REV_CNT_W)
// PORTS
//  clk          in   1          single clock, all state on posedge
//  rst          in   1          asynchronous, active-high reset
//  en           in   1          sample q_in this cycle
//  q_in         in   4          Johnson code from the upstream counter
//  clr_err      in   1          synchronous clear of err_cnt and err_sticky
//  phase        out  3          decoded phase index (registered)
//  phase_oh     out  8          one-hot phase; all zero when code illegal
//  phase_vld    out  1          last sample was a legal code
//  locked       out  1          sequence is locked
//  wrap         out  1          1-cycle pulse on a correct 7->0 step
//  rev_cnt      out  REV_CNT_W  revolutions completed while locked
//  err_illegal  out  1          1-cycle pulse: sampled code not in the legal set
//  err_seq      out  1          1-cycle pulse: legal code but not successor of previous
//  err_cnt      out  ERR_CNT_W  saturating count of error events
//  err_sticky   out  1          set on any error, held until clr_err
// BEHAVIOUR
//  - Decode map: 0001->0, 0011->1, 0111->2, 1111->3, 1110->4, 1100->5, 1000->6, 0000->7.
//    The other 8 codes are illegal.
//  - Latency: outputs reflect the q_in sampled with en=1 one clock later. When en=0, all
//    registers hold and all pulses (wrap, err_*) are 0.
//  - Legal sample: phase <= index, phase_oh <= 1<<index, phase_vld <= 1.
//  - Illegal sample: phase holds, phase_oh <= 0, phase_vld <= 0, err_illegal pulses, and
//    the prev_ok flag clears.
//  - Step check: runs only when prev_ok=1. Expected index = (prev+1) mod 8.
//    A repeated code is a seq error. A mismatch pulses err_seq.
//  - The first legal sample after reset or after an illegal code is not step-checked.
//    It sets prev_ok.
//  - FSM (state encoding in shared include):
//    UNLOCK: legal sample -> ACQ, good=0.
//    ACQ: correct step -> good++; good reaching LOCK_CNT -> LOCKED. Any error -> UNLOCK.
//    LOCKED: any error -> UNLOCK (locked drops the cycle after the error sample).
//  - locked = (state==LOCKED), registered.
//  - wrap pulses on any correct 7->0 step. rev_cnt increments on wrap only if already
//    LOCKED.
//  - err_cnt += 1 per errored sample (illegal and seq are mutually exclusive) and
//    saturates at all-ones. err_sticky <= 1 on any error.
//  - clr_err coincident with an error: clear applies first, then the new error counts,
//    giving err_cnt=1 and err_sticky=1.
//  - Reset (async, any time): phase=0, phase_oh=0, phase_vld=0, locked=0, wrap=0,
//    rev_cnt=0, err_illegal=0, err_seq=0, err_cnt=0, err_sticky=0, state=UNLOCK,
//    prev_ok=0, good=0.
// STRUCTURE
//  - johnson_defs.vh: the 8 legal code constants, FSM state localparams (UNLOCK/ACQ/LOCKED).
//  - Sub-module johnson_decode: combinational q_in -> {legal, idx[2:0]}.
//  - Top: FSM, step checker, counters, output registers.
// TESTING
//  1. Reset, then en=1 with q_in stepping 1,3,7,15,14,12,8,0,1 -> phase 0..7,0;
//     locked=1 after the 5th sample's output; wrap pulse on the 0->1 step (phase 7->0),
//     rev_cnt=1.
//  2. Locked, inject q_in=4'b0101 -> err_illegal=1, phase_oh=0, phase_vld=0, locked=0,
//     err_cnt=1. Resume legal codes -> relock after 1+LOCK_CNT samples.
//  3. Locked at phase 2 (7), apply 12 (phase 5) -> err_seq=1, locked=0, err_sticky=1,
//     phase=5.
//  4. Repeat the same code twice -> err_seq on the 2nd. Hold en=0 for 10 cycles -> no
//     pulses, all outputs stable.
//  5. ERR_CNT_W=2: force 5 errors -> err_cnt=3 (saturated). clr_err with a concurrent
//     error -> err_cnt=1, err_sticky=1.
//  6. Assert rst asynchronously mid-revolution between clock edges -> all outputs
//     immediately at reset values. Next legal sample is not step-checked.

Source files
------------

// File: rtl/johnson_seq_monitor_pkg.sv
// -----------------------------------------------------------------------------
// johnson_seq_monitor_pkg
// Purpose : Shared definitions for the Johnson sequence monitor. Holds the eight
//           legal 4-bit Johnson codes in phase order, the lock FSM state type and
//           a small index-to-one-hot helper.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package johnson_seq_monitor_pkg;

  localparam logic [3:0] CODE_P0 = 4'b0001;
  localparam logic [3:0] CODE_P1 = 4'b0011;
  localparam logic [3:0] CODE_P2 = 4'b0111;
  localparam logic [3:0] CODE_P3 = 4'b1111;
  localparam logic [3:0] CODE_P4 = 4'b1110;
  localparam logic [3:0] CODE_P5 = 4'b1100;
  localparam logic [3:0] CODE_P6 = 4'b1000;
  localparam logic [3:0] CODE_P7 = 4'b0000;

  typedef enum logic [1:0] {
    ST_UNLOCK = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic [7:0] idx_to_oh(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/johnson_seq_monitor_if.sv
// -----------------------------------------------------------------------------
// johnson_seq_monitor_if
// Purpose : Bundles the sample inputs and the status outputs of the Johnson
//           sequence monitor.
// Signals : en, q_in[3:0], clr_err              (driven by master)
//           phase[2:0], phase_oh[7:0], phase_vld, locked, wrap,
//           rev_cnt[REV_CNT_W-1:0], err_illegal, err_seq,
//           err_cnt[ERR_CNT_W-1:0], err_sticky  (driven by slave / monitor)
// Modports: master (upstream driver / observer), slave (the monitor itself)
// -----------------------------------------------------------------------------
interface johnson_seq_monitor_if #(
  parameter int ERR_CNT_W = 8,
  parameter int REV_CNT_W = 16
) ();

  logic                 en;
  logic [3:0]           q_in;
  logic                 clr_err;
  logic [2:0]           phase;
  logic [7:0]           phase_oh;
  logic                 phase_vld;
  logic                 locked;
  logic                 wrap;
  logic [REV_CNT_W-1:0] rev_cnt;
  logic                 err_illegal;
  logic                 err_seq;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 err_sticky;

  modport master (
    output en, q_in, clr_err,
    input  phase, phase_oh, phase_vld, locked, wrap, rev_cnt,
           err_illegal, err_seq, err_cnt, err_sticky
  );

  modport slave (
    input  en, q_in, clr_err,
    output phase, phase_oh, phase_vld, locked, wrap, rev_cnt,
           err_illegal, err_seq, err_cnt, err_sticky
  );

endinterface

// File: rtl/johnson_seq_monitor_decode.sv
// -----------------------------------------------------------------------------
// johnson_seq_monitor_decode
// Purpose : Combinational decode of a 4-bit Johnson code into its phase index.
// Ports   : i_code[3:0]  Johnson code
//           o_legal      code is one of the eight legal codes
//           o_idx[2:0]   phase index (0 when illegal)
// -----------------------------------------------------------------------------
module johnson_seq_monitor_decode
  import johnson_seq_monitor_pkg::*;
(
  input  logic [3:0] i_code,
  output logic       o_legal,
  output logic [2:0] o_idx
);

  always_comb begin
    o_legal = 1'b1;
    o_idx   = 3'd0;
    case (i_code)
      CODE_P0: o_idx = 3'd0;
      CODE_P1: o_idx = 3'd1;
      CODE_P2: o_idx = 3'd2;
      CODE_P3: o_idx = 3'd3;
      CODE_P4: o_idx = 3'd4;
      CODE_P5: o_idx = 3'd5;
      CODE_P6: o_idx = 3'd6;
      CODE_P7: o_idx = 3'd7;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/johnson_seq_monitor.sv
// -----------------------------------------------------------------------------
// johnson_seq_monitor
// Purpose : Samples a 4-bit Johnson counter on enabled cycles, decodes it to a
//           phase index and one-hot phase, checks every code and every step
//           against the legal 8-state sequence, tracks lock, counts completed
//           revolutions while locked, and counts error events (saturating).
// Ports   : clk         clock, all state on posedge
//           rst         asynchronous active-high reset
//           bus         johnson_seq_monitor_if.slave (en, q_in, clr_err in;
//                       phase, phase_oh, phase_vld, locked, wrap, rev_cnt,
//                       err_illegal, err_seq, err_cnt, err_sticky out)
// -----------------------------------------------------------------------------
module johnson_seq_monitor
  import johnson_seq_monitor_pkg::*;
#(
  parameter int LOCK_CNT  = 4,
  parameter int ERR_CNT_W = 8,
  parameter int REV_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  johnson_seq_monitor_if.slave  bus
);

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  logic                 w_legal;
  logic [2:0]           w_idx;
  logic [2:0]           w_exp_idx;
  logic                 w_checked;
  logic                 w_step_ok;
  logic                 w_err_illegal;
  logic                 w_err_seq;
  logic                 w_err;
  logic                 w_wrap;
  logic [3:0]           w_good_inc;
  state_t               w_state_nxt;
  logic [3:0]           w_good_nxt;

  state_t               r_state;
  logic [3:0]           r_good;
  logic                 r_prev_ok;
  logic [2:0]           r_phase;
  logic [7:0]           r_phase_oh;
  logic                 r_phase_vld;
  logic                 r_locked;
  logic                 r_wrap;
  logic [REV_CNT_W-1:0] r_rev_cnt;
  logic                 r_err_illegal;
  logic                 r_err_seq;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 r_err_sticky;

  johnson_seq_monitor_decode u_decode (
    .i_code  (bus.q_in),
    .o_legal (w_legal),
    .o_idx   (w_idx)
  );

  // Step checker: r_phase is the previous legal index; it is only trusted
  // while r_prev_ok is set (cleared by reset and by any illegal code).
  assign w_exp_idx     = r_phase + 3'd1;
  assign w_checked     = bus.en & w_legal & r_prev_ok;
  assign w_step_ok     = w_checked & (w_idx == w_exp_idx);
  assign w_err_seq     = w_checked & (w_idx != w_exp_idx);
  assign w_err_illegal = bus.en & ~w_legal;
  assign w_err         = w_err_illegal | w_err_seq;
  assign w_wrap        = w_step_ok & (r_phase == 3'd7);
  assign w_good_inc    = r_good + 4'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    if (bus.en) begin
      case (r_state)
        ST_UNLOCK: begin
          if (w_legal) begin
            w_state_nxt = ST_ACQ;
            w_good_nxt  = 4'd0;
          end
        end
        ST_ACQ: begin
          if (w_err) begin
            w_state_nxt = ST_UNLOCK;
          end else if (w_step_ok) begin
            w_good_nxt = w_good_inc;
            if (w_good_inc == LOCK_TGT) w_state_nxt = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_err) w_state_nxt = ST_UNLOCK;
        end
        default: w_state_nxt = ST_UNLOCK;
      endcase
    end
  end

  // Register stage: everything below updates one clock after the sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_UNLOCK;
      r_good        <= 4'd0;
      r_prev_ok     <= 1'b0;
      r_phase       <= 3'd0;
      r_phase_oh    <= 8'd0;
      r_phase_vld   <= 1'b0;
      r_locked      <= 1'b0;
      r_wrap        <= 1'b0;
      r_rev_cnt     <= '0;
      r_err_illegal <= 1'b0;
      r_err_seq     <= 1'b0;
      r_err_cnt     <= '0;
      r_err_sticky  <= 1'b0;
    end else begin
      r_wrap        <= 1'b0;
      r_err_illegal <= 1'b0;
      r_err_seq     <= 1'b0;
      if (bus.clr_err) begin
        r_err_cnt    <= '0;
        r_err_sticky <= 1'b0;
      end
      if (bus.en) begin
        r_state       <= w_state_nxt;
        r_good        <= w_good_nxt;
        r_locked      <= (w_state_nxt == ST_LOCKED);
        r_wrap        <= w_wrap;
        r_err_illegal <= w_err_illegal;
        r_err_seq     <= w_err_seq;
        if (w_legal) begin
          r_phase     <= w_idx;
          r_phase_oh  <= idx_to_oh(w_idx);
          r_phase_vld <= 1'b1;
          r_prev_ok   <= 1'b1;
        end else begin
          r_phase_oh  <= 8'd0;
          r_phase_vld <= 1'b0;
          r_prev_ok   <= 1'b0;
        end
        // Only revolutions finished from an already-locked state count.
        if (w_wrap && (r_state == ST_LOCKED)) r_rev_cnt <= r_rev_cnt + REV_CNT_W'(1);
        // A coincident clear wins first, so the new error lands on zero.
        if (w_err) begin
          r_err_cnt    <= bus.clr_err ? ERR_CNT_W'(1) : sat_inc(r_err_cnt);
          r_err_sticky <= 1'b1;
        end
      end
    end
  end

  assign bus.phase       = r_phase;
  assign bus.phase_oh    = r_phase_oh;
  assign bus.phase_vld   = r_phase_vld;
  assign bus.locked      = r_locked;
  assign bus.wrap        = r_wrap;
  assign bus.rev_cnt     = r_rev_cnt;
  assign bus.err_illegal = r_err_illegal;
  assign bus.err_seq     = r_err_seq;
  assign bus.err_cnt     = r_err_cnt;
  assign bus.err_sticky  = r_err_sticky;

endmodule

// File: tb/tb_johnson_seq_monitor.sv
// -----------------------------------------------------------------------------
// tb_johnson_seq_monitor
// Purpose : Directed-vector scoreboard bench for johnson_seq_monitor
//           (LOCK_CNT=4, ERR_CNT_W=2, REV_CNT_W=16). Each vector carries its
//           hand-computed expected outputs into a queue; a monitor pops and
//           compares one clock after the vector is applied.
// -----------------------------------------------------------------------------
module tb_johnson_seq_monitor;

  typedef struct packed {
    logic [2:0]  ph;
    logic [7:0]  oh;
    logic        vld;
    logic        lk;
    logic        wr;
    logic [15:0] rev;
    logic        ill;
    logic        sq;
    logic [1:0]  ec;
    logic        st;
  } obs_t;

  typedef struct {
    int   due;
    int   id;
    obs_t o;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   vec_id = 0;
  exp_t sb[$];

  johnson_seq_monitor_if #(.ERR_CNT_W(2), .REV_CNT_W(16)) bus ();

  johnson_seq_monitor #(.LOCK_CNT(4), .ERR_CNT_W(2), .REV_CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t get_obs();
    obs_t a;
    a.ph  = bus.phase;
    a.oh  = bus.phase_oh;
    a.vld = bus.phase_vld;
    a.lk  = bus.locked;
    a.wr  = bus.wrap;
    a.rev = bus.rev_cnt;
    a.ill = bus.err_illegal;
    a.sq  = bus.err_seq;
    a.ec  = bus.err_cnt;
    a.st  = bus.err_sticky;
    return a;
  endfunction

  task automatic compare(input string name, input obs_t a, input obs_t e);
    n_checks++;
    if (a === e) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got ph=%0d oh=%b vld=%b lk=%b wr=%b rev=%0d ill=%b seq=%b ec=%0d st=%b | expected ph=%0d oh=%b vld=%b lk=%b wr=%b rev=%0d ill=%b seq=%b ec=%0d st=%b",
               name, a.ph, a.oh, a.vld, a.lk, a.wr, a.rev, a.ill, a.sq, a.ec, a.st,
               e.ph, e.oh, e.vld, e.lk, e.wr, e.rev, e.ill, e.sq, e.ec, e.st);
    end
  endtask

  // Apply one sample and queue what the outputs must be one clock later.
  task automatic s(input logic e, input logic [3:0] q, input logic c,
                   input logic [2:0] ph, input logic vld, input logic lk, input logic wr,
                   input logic [15:0] rev, input logic ill, input logic sq,
                   input logic [1:0] ec, input logic st);
    exp_t x;
    @(negedge clk);
    bus.en      = e;
    bus.q_in    = q;
    bus.clr_err = c;
    x.due   = cyc + 1;
    x.id    = vec_id;
    x.o.ph  = ph;
    x.o.oh  = vld ? (8'b0000_0001 << ph) : 8'd0;
    x.o.vld = vld;
    x.o.lk  = lk;
    x.o.wr  = wr;
    x.o.rev = rev;
    x.o.ill = ill;
    x.o.sq  = sq;
    x.o.ec  = ec;
    x.o.st  = st;
    sb.push_back(x);
    vec_id++;
  endtask

  task automatic monitor();
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        x = sb.pop_front();
        compare($sformatf("vec%0d", x.id), get_obs(), x.o);
      end
    end
  endtask

  task automatic stimulus();
    bus.en = 1'b0; bus.q_in = 4'd0; bus.clr_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare("reset_state", get_obs(), '0);
    rst = 1'b0;

    // Full revolution from reset, lock after the 5th sample, wrap on 7->0.
    s(1, 4'd1,  0, 3'd0, 1, 0, 0, 16'd0, 0, 0, 2'd0, 0);
    s(1, 4'd3,  0, 3'd1, 1, 0, 0, 16'd0, 0, 0, 2'd0, 0);
    s(1, 4'd7,  0, 3'd2, 1, 0, 0, 16'd0, 0, 0, 2'd0, 0);
    s(1, 4'd15, 0, 3'd3, 1, 0, 0, 16'd0, 0, 0, 2'd0, 0);
    s(1, 4'd14, 0, 3'd4, 1, 1, 0, 16'd0, 0, 0, 2'd0, 0);
    s(1, 4'd12, 0, 3'd5, 1, 1, 0, 16'd0, 0, 0, 2'd0, 0);
    s(1, 4'd8,  0, 3'd6, 1, 1, 0, 16'd0, 0, 0, 2'd0, 0);
    s(1, 4'd0,  0, 3'd7, 1, 1, 0, 16'd0, 0, 0, 2'd0, 0);
    s(1, 4'd1,  0, 3'd0, 1, 1, 1, 16'd1, 0, 0, 2'd0, 0);
    s(1, 4'd3,  0, 3'd1, 1, 1, 0, 16'd1, 0, 0, 2'd0, 0);
    // Illegal code while locked, then relock after 1+LOCK_CNT samples.
    s(1, 4'd5,  0, 3'd1, 0, 0, 0, 16'd1, 1, 0, 2'd1, 1);
    s(1, 4'd7,  0, 3'd2, 1, 0, 0, 16'd1, 0, 0, 2'd1, 1);
    s(1, 4'd15, 0, 3'd3, 1, 0, 0, 16'd1, 0, 0, 2'd1, 1);
    s(1, 4'd14, 0, 3'd4, 1, 0, 0, 16'd1, 0, 0, 2'd1, 1);
    s(1, 4'd12, 0, 3'd5, 1, 0, 0, 16'd1, 0, 0, 2'd1, 1);
    s(1, 4'd8,  0, 3'd6, 1, 1, 0, 16'd1, 0, 0, 2'd1, 1);
    s(1, 4'd0,  0, 3'd7, 1, 1, 0, 16'd1, 0, 0, 2'd1, 1);
    s(1, 4'd1,  0, 3'd0, 1, 1, 1, 16'd2, 0, 0, 2'd1, 1);
    s(1, 4'd3,  0, 3'd1, 1, 1, 0, 16'd2, 0, 0, 2'd1, 1);
    s(1, 4'd7,  0, 3'd2, 1, 1, 0, 16'd2, 0, 0, 2'd1, 1);
    // Skip from phase 2 to phase 5, then repeat the same code.
    s(1, 4'd12, 0, 3'd5, 1, 0, 0, 16'd2, 0, 1, 2'd2, 1);
    s(1, 4'd12, 0, 3'd5, 1, 0, 0, 16'd2, 0, 1, 2'd3, 1);
    // en low: inputs ignored, everything holds, no pulses.
    for (int i = 0; i < 10; i++)
      s(0, (i % 2 == 0) ? 4'd5 : 4'd3, 0, 3'd5, 1, 0, 0, 16'd2, 0, 0, 2'd3, 1);
    // Saturation with ERR_CNT_W=2, then clear coincident with an error.
    s(1, 4'd5,  0, 3'd5, 0, 0, 0, 16'd2, 1, 0, 2'd3, 1);
    s(1, 4'd9,  0, 3'd5, 0, 0, 0, 16'd2, 1, 0, 2'd3, 1);
    s(1, 4'd10, 1, 3'd5, 0, 0, 0, 16'd2, 1, 0, 2'd1, 1);
    s(1, 4'd1,  1, 3'd0, 1, 0, 0, 16'd2, 0, 0, 2'd0, 0);
    s(1, 4'd3,  0, 3'd1, 1, 0, 0, 16'd2, 0, 0, 2'd0, 0);
    s(1, 4'd7,  0, 3'd2, 1, 0, 0, 16'd2, 0, 0, 2'd0, 0);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    bus.en = 1'b0;
    #2 rst = 1'b1;
    #1 compare("async_reset", get_obs(), '0);
    @(negedge clk);
    rst = 1'b0;

    // First sample after reset is not step-checked; checking resumes after.
    s(1, 4'd14, 0, 3'd4, 1, 0, 0, 16'd0, 0, 0, 2'd0, 0);
    s(1, 4'd8,  0, 3'd6, 1, 0, 0, 16'd0, 0, 1, 2'd1, 1);
    s(1, 4'd0,  0, 3'd7, 1, 0, 0, 16'd0, 0, 0, 2'd1, 1);
    @(negedge clk);
    bus.en = 1'b0;

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish before 200000");
        $fatal(1, "timeout");
      end
    join_any
    disable fork;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
